// File: rtl/data_path_pkg.sv
// Shared definitions for the data_path CPU datapath.
// Holds the ALU opcode encodings, the bus source indices used by the bus
// encoder, and a helper that forms the constant (C) bus source from IR.
package data_path_pkg;

    localparam int WORD_W = 32;

    // ALU opcodes
    localparam logic [4:0] OP_AND  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Bus source indices; a lower index has higher priority on the bus.
    localparam int BUS_R0      = 0;
    localparam int BUS_HI      = 16;
    localparam int BUS_LO      = 17;
    localparam int BUS_ZHI     = 18;
    localparam int BUS_ZLO     = 19;
    localparam int BUS_PC      = 20;
    localparam int BUS_MDR     = 21;
    localparam int BUS_INPORT  = 22;
    localparam int BUS_C       = 23;
    localparam int BUS_NUM_SRC = 24;

    // Immediate field IR[18:0] sign-extended to a full word.
    function automatic logic [WORD_W-1:0] c_sign_ext(input logic [18:0] imm);
        return {{(WORD_W-19){imm[18]}}, imm};
    endfunction

endpackage

// File: rtl/data_path_alu.sv
// Combinational ALU of the datapath.
// Ports:
//   a_i      operand A (Y register)
//   b_i      operand B (bus)
//   opcode_i operation select
//   inc_pc_i forces result = b_i + 1, overriding opcode
//   z_o      64-bit result {Zhi, Zlo}
module alu
    import data_path_pkg::*;
(
    input  logic [WORD_W-1:0]   a_i,
    input  logic [WORD_W-1:0]   b_i,
    input  logic [4:0]          opcode_i,
    input  logic                inc_pc_i,
    output logic [2*WORD_W-1:0] z_o
);

    logic [4:0]                 sh;
    logic [5:0]                 sh_inv;
    logic signed [2*WORD_W-1:0] prod;
    logic [WORD_W-1:0]          quot;
    logic [WORD_W-1:0]          rem;

    assign sh     = b_i[4:0];
    assign sh_inv = 6'd32 - {1'b0, sh};   // a shift by 32 yields 0, so sh = 0 rotates to a_i
    assign prod   = $signed({{WORD_W{a_i[WORD_W-1]}}, a_i}) * $signed({{WORD_W{b_i[WORD_W-1]}}, b_i});

    // Division by zero must produce zero rather than X.
    always_comb begin
        quot = '0;
        rem  = '0;
        if (b_i != '0) begin
            quot = $signed(a_i) / $signed(b_i);
            rem  = $signed(a_i) % $signed(b_i);
        end
    end

    always_comb begin
        // NOTE: z_o is assigned a default first so no path through the case leaves it unassigned (no latch).
        z_o = '0;
        if (inc_pc_i) begin
            z_o[WORD_W-1:0] = b_i + 1'b1;
        end else begin
            unique case (opcode_i)
                OP_AND:  z_o[WORD_W-1:0] = a_i & b_i;
                OP_OR:   z_o[WORD_W-1:0] = a_i | b_i;
                OP_ADD:  z_o[WORD_W-1:0] = a_i + b_i;
                OP_SUB:  z_o[WORD_W-1:0] = a_i - b_i;
                OP_SHR:  z_o[WORD_W-1:0] = a_i >> sh;
                OP_SHRA: z_o[WORD_W-1:0] = $signed(a_i) >>> sh;
                OP_SHL:  z_o[WORD_W-1:0] = a_i << sh;
                OP_ROR:  z_o[WORD_W-1:0] = (a_i >> sh) | (a_i << sh_inv);
                OP_ROL:  z_o[WORD_W-1:0] = (a_i << sh) | (a_i >> sh_inv);
                OP_MUL:  z_o = prod;
                OP_DIV:  z_o = {rem, quot};
                OP_NEG:  z_o[WORD_W-1:0] = -b_i;
                OP_NOT:  z_o[WORD_W-1:0] = ~b_i;
                default: z_o[WORD_W-1:0] = b_i;
            endcase
        end
    end

endmodule

// File: rtl/data_path.sv
// Single-bus CPU datapath: general registers R0-R15, PC, IR, Y, Z (64-bit),
// MAR, MDR, HI, LO, Inport and Outport around one shared bus and an ALU.
// Ports:
//   clock / clear                 rising-edge clock, async active-low reset
//   R*in, IRin .. Inport_in       register load enables
//   R*out, HIout .. Cout          bus source selects (lowest index wins)
//   IncPC, opcode                 ALU control
//   Mem_read, MDR_Mem_lines       MDR input select and memory read data
//   Inport_data_in                external input port data
//   MAR_to_chip, Outport_data_out MAR and Outport contents
//   reg1..reg7, regMDR, PC/HI/LO/IR_VALUE, BusMuxOut_out  debug views
module data_path
    import data_path_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic clock,
    input  logic clear,
    input  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in,
    input  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout,
    input  logic IncPC,
    input  logic [4:0] opcode,
    input  logic Mem_read,
    input  logic [DATA_WIDTH-1:0] MDR_Mem_lines,
    input  logic [DATA_WIDTH-1:0] Inport_data_in,
    output logic [DATA_WIDTH-1:0] MAR_to_chip,
    output logic [DATA_WIDTH-1:0] Outport_data_out,
    output logic [DATA_WIDTH-1:0] reg1, reg2, reg3, reg4, reg5, reg6, reg7,
    output logic [DATA_WIDTH-1:0] regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE,
    output logic [DATA_WIDTH-1:0] BusMuxOut_out
);

    logic [15:0]             r_in;
    logic [15:0]             r_out;
    logic [DATA_WIDTH-1:0]   r_q [16];
    logic [DATA_WIDTH-1:0]   pc_q, ir_q, y_q, mar_q, mdr_q, hi_q, lo_q, inport_q, outport_q;
    logic [2*DATA_WIDTH-1:0] z_q;
    logic [2*DATA_WIDTH-1:0] alu_z;
    logic [DATA_WIDTH-1:0]   mdr_d;
    logic [DATA_WIDTH-1:0]   bus;
    logic [BUS_NUM_SRC-1:0]  bus_sel;
    logic [DATA_WIDTH-1:0]   bus_src [BUS_NUM_SRC];

    assign r_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
    assign r_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    // Bit position in bus_sel equals the source's bus index.
    assign bus_sel = {Cout, Inport_out, MDRout, PCout, Zlo_out, Zhi_out, LOout, HIout, r_out};

    always_comb begin
        for (int i = 0; i < 16; i++) bus_src[BUS_R0 + i] = r_q[i];
        bus_src[BUS_HI]     = hi_q;
        bus_src[BUS_LO]     = lo_q;
        bus_src[BUS_ZHI]    = z_q[2*DATA_WIDTH-1:DATA_WIDTH];
        bus_src[BUS_ZLO]    = z_q[DATA_WIDTH-1:0];
        bus_src[BUS_PC]     = pc_q;
        bus_src[BUS_MDR]    = mdr_q;
        bus_src[BUS_INPORT] = inport_q;
        bus_src[BUS_C]      = c_sign_ext(ir_q[18:0]);
    end

    // Scanning from the highest index down lets the lowest selected index
    // overwrite the rest; with nothing selected the bus stays 0.
    always_comb begin
        bus = '0;
        for (int i = BUS_NUM_SRC - 1; i >= 0; i--) begin
            if (bus_sel[i]) bus = bus_src[i];
        end
    end

    assign mdr_d = Mem_read ? MDR_Mem_lines : bus;

    alu u_alu (
        .a_i      (y_q),
        .b_i      (bus),
        .opcode_i (opcode),
        .inc_pc_i (IncPC),
        .z_o      (alu_z)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            // NOTE: the register file is an array of flops, not a RAM, so every entry is reset explicitly.
            for (int i = 0; i < 16; i++) r_q[i] <= '0;
            pc_q      <= '0;
            ir_q      <= '0;
            y_q       <= '0;
            z_q       <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            inport_q  <= '0;
            outport_q <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the bus value from before this edge.
            for (int i = 0; i < 16; i++) begin
                if (r_in[i]) r_q[i] <= bus;
            end
            if (PCin)       pc_q      <= bus;
            if (IRin)       ir_q      <= bus;
            if (RYin)       y_q       <= bus;
            if (RZin)       z_q       <= alu_z;
            if (MARin)      mar_q     <= bus;
            if (MDRin)      mdr_q     <= mdr_d;
            if (HIin)       hi_q      <= bus;
            if (LOin)       lo_q      <= bus;
            if (Inport_in)  inport_q  <= Inport_data_in;
            if (Outport_in) outport_q <= bus;
        end
    end

    assign MAR_to_chip      = mar_q;
    assign Outport_data_out = outport_q;
    assign reg1             = r_q[1];
    assign reg2             = r_q[2];
    assign reg3             = r_q[3];
    assign reg4             = r_q[4];
    assign reg5             = r_q[5];
    assign reg6             = r_q[6];
    assign reg7             = r_q[7];
    assign regMDR           = mdr_q;
    assign PC_VALUE         = pc_q;
    assign HI_VALUE         = hi_q;
    assign LO_VALUE         = lo_q;
    assign IR_VALUE         = ir_q;
    assign BusMuxOut_out    = bus;

endmodule

// File: tb/tb_data_path.sv
// Self-checking bench for data_path: directed scenarios plus randomized ALU
// and bus-priority stimulus compared against an arithmetic reference model.
module tb_data_path;
    import data_path_pkg::*;

    logic        clock = 1'b0;
    logic        clear;
    logic [15:0] r_in, r_out;
    logic        IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in;
    logic        HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout;
    logic        IncPC, Mem_read;
    logic [4:0]  opcode;
    logic [31:0] MDR_Mem_lines, Inport_data_in;
    logic [31:0] MAR_to_chip, Outport_data_out;
    logic [31:0] reg1, reg2, reg3, reg4, reg5, reg6, reg7;
    logic [31:0] regMDR, PC_VALUE, HI_VALUE, LO_VALUE, IR_VALUE, BusMuxOut_out;

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic [31:0] rmodel [16];

    always #5 clock = ~clock;

    data_path #(.DATA_WIDTH(32)) dut (
        .clock(clock), .clear(clear),
        .R0in(r_in[0]), .R1in(r_in[1]), .R2in(r_in[2]), .R3in(r_in[3]),
        .R4in(r_in[4]), .R5in(r_in[5]), .R6in(r_in[6]), .R7in(r_in[7]),
        .R8in(r_in[8]), .R9in(r_in[9]), .R10in(r_in[10]), .R11in(r_in[11]),
        .R12in(r_in[12]), .R13in(r_in[13]), .R14in(r_in[14]), .R15in(r_in[15]),
        .IRin(IRin), .PCin(PCin), .RYin(RYin), .RZin(RZin), .MARin(MARin),
        .MDRin(MDRin), .HIin(HIin), .LOin(LOin), .Outport_in(Outport_in), .Inport_in(Inport_in),
        .R0out(r_out[0]), .R1out(r_out[1]), .R2out(r_out[2]), .R3out(r_out[3]),
        .R4out(r_out[4]), .R5out(r_out[5]), .R6out(r_out[6]), .R7out(r_out[7]),
        .R8out(r_out[8]), .R9out(r_out[9]), .R10out(r_out[10]), .R11out(r_out[11]),
        .R12out(r_out[12]), .R13out(r_out[13]), .R14out(r_out[14]), .R15out(r_out[15]),
        .HIout(HIout), .LOout(LOout), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
        .PCout(PCout), .MDRout(MDRout), .Inport_out(Inport_out), .Cout(Cout),
        .IncPC(IncPC), .opcode(opcode), .Mem_read(Mem_read),
        .MDR_Mem_lines(MDR_Mem_lines), .Inport_data_in(Inport_data_in),
        .MAR_to_chip(MAR_to_chip), .Outport_data_out(Outport_data_out),
        .reg1(reg1), .reg2(reg2), .reg3(reg3), .reg4(reg4), .reg5(reg5), .reg6(reg6), .reg7(reg7),
        .regMDR(regMDR), .PC_VALUE(PC_VALUE), .HI_VALUE(HI_VALUE), .LO_VALUE(LO_VALUE),
        .IR_VALUE(IR_VALUE), .BusMuxOut_out(BusMuxOut_out)
    );

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_alu(input logic [4:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input bit inc);
        longint sa, sb, ua, p, q;
        logic [31:0] r;
        int n;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'h0, a});
        n  = int'(b % 32);
        p  = longint'(1) << n;
        r  = a;
        if (inc) return {32'h0, 32'(longint'({32'h0, b}) + 1)};
        case (op)
            OP_AND:  return {32'h0, a & b};
            OP_OR:   return {32'h0, a | b};
            OP_ADD:  return {32'h0, 32'(sa + sb)};
            OP_SUB:  return {32'h0, 32'(sa - sb)};
            OP_SHR:  return {32'h0, 32'(ua / p)};
            OP_SHRA: begin
                q = sa / p;
                if (sa < 0 && (sa % p) != 0) q = q - 1;
                return {32'h0, 32'(q)};
            end
            OP_SHL:  return {32'h0, 32'(ua * p)};
            OP_ROR:  begin repeat (n) r = {r[0], r[31:1]}; return {32'h0, r}; end
            OP_ROL:  begin repeat (n) r = {r[30:0], r[31]}; return {32'h0, r}; end
            OP_MUL:  return 64'(sa * sb);
            OP_DIV:  begin
                if (b == 32'h0) return 64'h0;
                return {32'(sa % sb), 32'(sa / sb)};
            end
            OP_NEG:  return {32'h0, 32'(-sb)};
            OP_NOT:  return {32'h0, ~b};
            default: return {32'h0, b};
        endcase
    endfunction

    function automatic logic [31:0] model_c(input logic [31:0] ir);
        int v;
        v = int'(ir % 32'h80000);
        if (v >= 32'h40000) v = v - 32'h80000;
        return 32'(v);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        r_in = '0; r_out = '0;
        {IRin, PCin, RYin, RZin, MARin, MDRin, HIin, LOin, Outport_in, Inport_in} = '0;
        {HIout, LOout, Zhi_out, Zlo_out, PCout, MDRout, Inport_out, Cout} = '0;
        IncPC = 1'b0; Mem_read = 1'b0; opcode = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load_inport(input logic [31:0] v);
        Inport_data_in = v; Inport_in = 1'b1;
        tick();
        Inport_in = 1'b0;
    endtask

    task automatic put_reg(input int idx, input logic [31:0] v);
        load_inport(v);
        Inport_out = 1'b1; r_in[idx] = 1'b1;
        tick(); idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] obs [15];
        idle();
        MDR_Mem_lines = '0; Inport_data_in = 32'h1234_5678;
        clear = 1'b0;
        #2;
        obs = '{reg1, reg2, reg3, reg4, reg5, reg6, reg7, regMDR, PC_VALUE, HI_VALUE,
                LO_VALUE, IR_VALUE, MAR_to_chip, Outport_data_out, BusMuxOut_out};
        for (int i = 0; i < 15; i++) begin
            total_cnt++;
            if (obs[i] !== 32'h0) $display("FAIL reset_out%0d: got %h expected 00000000", i, obs[i]);
            else pass_cnt++;
        end
        // Loads requested while clear is low must be ignored.
        Inport_in = 1'b1; Inport_out = 1'b1; r_in[3] = 1'b1; PCin = 1'b1;
        tick();
        total_cnt++;
        if (reg3 !== 32'h0 || PC_VALUE !== 32'h0)
            $display("FAIL reset_dominates: reg3=%h pc=%h expected 0", reg3, PC_VALUE);
        else pass_cnt++;
        idle();
        #2 clear = 1'b1;
        tick();
    endtask

    task automatic test_mdr_pc();
        MDR_Mem_lines = 32'h10; Mem_read = 1'b1; MDRin = 1'b1;
        tick(); idle();
        total_cnt++;
        if (regMDR !== 32'h10) $display("FAIL mdr_mem: got %h expected 00000010", regMDR);
        else pass_cnt++;
        MDRout = 1'b1; r_in[7] = 1'b1; PCin = 1'b1;
        tick(); idle();
        total_cnt++;
        if (reg7 !== 32'h10 || PC_VALUE !== 32'h10)
            $display("FAIL mdr_to_r7_pc: reg7=%h pc=%h expected 00000010", reg7, PC_VALUE);
        else pass_cnt++;
        // Mem_read = 0 loads MDR from the bus; memory lines are ignored.
        load_inport(32'hCAFE_0001);
        Inport_out = 1'b1; MDRin = 1'b1; MDR_Mem_lines = 32'hDEAD_BEEF;
        tick(); idle();
        total_cnt++;
        if (regMDR !== 32'hCAFE_0001) $display("FAIL mdr_from_bus: got %h expected cafe0001", regMDR);
        else pass_cnt++;
        // Without MDRin the memory lines must not reach MDR.
        Mem_read = 1'b1;
        tick(); idle();
        total_cnt++;
        if (regMDR !== 32'hCAFE_0001) $display("FAIL mdr_hold: got %h expected cafe0001", regMDR);
        else pass_cnt++;
    endtask

    task automatic test_inc_pc();
        PCout = 1'b1; IncPC = 1'b1; opcode = OP_MUL; RZin = 1'b1; MARin = 1'b1;
        tick(); idle();
        total_cnt++;
        if (MAR_to_chip !== 32'h10) $display("FAIL incpc_mar: got %h expected 00000010", MAR_to_chip);
        else pass_cnt++;
        Zlo_out = 1'b1; PCin = 1'b1;
        tick(); idle();
        total_cnt++;
        if (PC_VALUE !== 32'h11) $display("FAIL incpc_pc: got %h expected 00000011", PC_VALUE);
        else pass_cnt++;
    endtask

    task automatic test_ir_c();
        logic [31:0] irs [3];
        irs = '{32'h2891_8000, 32'h0004_0005, $urandom};
        for (int i = 0; i < 3; i++) begin
            MDR_Mem_lines = irs[i]; Mem_read = 1'b1; MDRin = 1'b1;
            tick(); idle();
            MDRout = 1'b1; IRin = 1'b1;
            tick(); idle();
            total_cnt++;
            if (IR_VALUE !== irs[i]) $display("FAIL ir_load%0d: got %h expected %h", i, IR_VALUE, irs[i]);
            else pass_cnt++;
            Cout = 1'b1; #1;
            total_cnt++;
            if (BusMuxOut_out !== model_c(irs[i]))
                $display("FAIL c_sign_ext%0d: got %h expected %h", i, BusMuxOut_out, model_c(irs[i]));
            else pass_cnt++;
            idle();
        end
    endtask

    task automatic test_neg_not();
        logic [4:0]  ops [2];
        logic [31:0] exps [2];
        ops  = '{OP_NEG, OP_NOT};
        exps = '{32'hFFFF_FFF0, 32'hFFFF_FFEF};
        for (int i = 0; i < 2; i++) begin
            r_out[7] = 1'b1; opcode = ops[i]; RZin = 1'b1;
            tick(); idle();
            Zlo_out = 1'b1; r_in[6] = 1'b1;
            tick(); idle();
            total_cnt++;
            if (reg6 !== exps[i]) $display("FAIL neg_not%0d: got %h expected %h", i, reg6, exps[i]);
            else pass_cnt++;
        end
    endtask

    task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input bit inc);
        logic [63:0] expv;
        load_inport(a);
        Inport_out = 1'b1; RYin = 1'b1;
        tick(); idle();
        load_inport(b);
        Inport_out = 1'b1; opcode = op; IncPC = inc; RZin = 1'b1;
        tick(); idle();
        expv = model_alu(op, a, b, inc);
        Zhi_out = 1'b1; #1;
        total_cnt++;
        if (BusMuxOut_out !== expv[63:32])
            $display("FAIL alu_zhi op=%b a=%h b=%h inc=%0d: got %h expected %h", op, a, b, inc, BusMuxOut_out, expv[63:32]);
        else pass_cnt++;
        Zhi_out = 1'b0; Zlo_out = 1'b1; #1;
        total_cnt++;
        if (BusMuxOut_out !== expv[31:0])
            $display("FAIL alu_zlo op=%b a=%h b=%h inc=%0d: got %h expected %h", op, a, b, inc, BusMuxOut_out, expv[31:0]);
        else pass_cnt++;
        Zlo_out = 1'b0;
    endtask

    task automatic test_alu_directed();
        run_alu(OP_MUL, 32'h6, 32'hFFFF_FFFE, 1'b0);
        // HI/LO capture of the product halves
        Zhi_out = 1'b1; HIin = 1'b1;
        tick(); idle();
        Zlo_out = 1'b1; LOin = 1'b1;
        tick(); idle();
        total_cnt++;
        if (HI_VALUE !== 32'hFFFF_FFFF || LO_VALUE !== 32'hFFFF_FFF4)
            $display("FAIL mul_hi_lo: hi=%h lo=%h expected ffffffff fffffff4", HI_VALUE, LO_VALUE);
        else pass_cnt++;
        run_alu(OP_DIV,  32'h7, 32'h2, 1'b0);
        run_alu(OP_DIV,  32'h7, 32'h0, 1'b0);
        run_alu(OP_DIV,  32'hFFFF_FFF9, 32'h2, 1'b0);
        run_alu(OP_NEG,  32'h0, 32'h8000_0000, 1'b0);
        run_alu(OP_ADD,  32'hFFFF_FFFF, 32'h1, 1'b0);
        run_alu(OP_SUB,  32'h0, 32'h1, 1'b0);
        run_alu(OP_SHRA, 32'h8000_0010, 32'h4, 1'b0);
        run_alu(OP_ROR,  32'h1234_5678, 32'h20, 1'b0);
        run_alu(OP_ROL,  32'h8000_0001, 32'h1F, 1'b0);
        run_alu(5'b11111, 32'h1, 32'hABCD_0123, 1'b0);
        run_alu(OP_MUL,  32'h5, 32'hFFFF_FFFF, 1'b1);
    endtask

    task automatic test_alu_random();
        logic [4:0]  op;
        logic [31:0] a, b;
        for (int k = 0; k < 40; k++) begin
            op = 5'($urandom_range(0, 31));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if (op == OP_DIV && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'h1;
            run_alu(op, a, b, ($urandom_range(0, 9) == 0));
        end
    endtask

    task automatic test_bus_priority();
        logic [31:0] expv;
        int lo_idx;
        for (int i = 0; i < 16; i++) begin
            rmodel[i] = $urandom;
            put_reg(i, rmodel[i]);
        end
        total_cnt++;
        if (reg7 !== rmodel[7]) $display("FAIL reg_hold: got %h expected %h", reg7, rmodel[7]);
        else pass_cnt++;
        r_out[1] = 1'b1; r_out[2] = 1'b1; #1;
        total_cnt++;
        if (BusMuxOut_out !== rmodel[1]) $display("FAIL bus_r1_r2: got %h expected %h", BusMuxOut_out, rmodel[1]);
        else pass_cnt++;
        idle();
        for (int k = 0; k < 8; k++) begin
            r_out = 16'($urandom) | 16'(1 << $urandom_range(0, 15));
            lo_idx = 16;
            for (int i = 15; i >= 0; i--) if (r_out[i]) lo_idx = i;
            expv = rmodel[lo_idx];
            if ($urandom_range(0, 1) == 1) begin HIout = 1'b1; Cout = 1'b1; end
            #1;
            total_cnt++;
            if (BusMuxOut_out !== expv)
                $display("FAIL bus_prio sel=%h: got %h expected %h", r_out, BusMuxOut_out, expv);
            else pass_cnt++;
            idle();
        end
        HIout = 1'b1; Cout = 1'b1; PCout = 1'b1; #1;
        total_cnt++;
        if (BusMuxOut_out !== HI_VALUE) $display("FAIL bus_hi_first: got %h expected %h", BusMuxOut_out, HI_VALUE);
        else pass_cnt++;
        idle(); #1;
        total_cnt++;
        if (BusMuxOut_out !== 32'h0) $display("FAIL bus_none: got %h expected 00000000", BusMuxOut_out);
        else pass_cnt++;
    endtask

    task automatic test_outport_mar();
        r_out[5] = 1'b1; Outport_in = 1'b1; MARin = 1'b1;
        tick(); idle();
        total_cnt++;
        if (Outport_data_out !== rmodel[5] || MAR_to_chip !== rmodel[5])
            $display("FAIL outport_mar: out=%h mar=%h expected %h", Outport_data_out, MAR_to_chip, rmodel[5]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] obs [15];
        load_inport(32'h1357_9BDF);
        Inport_out = 1'b1; r_in[7:1] = '1; RYin = 1'b1; RZin = 1'b1;
        {PCin, IRin, MARin, MDRin, HIin, LOin, Outport_in} = '1;
        tick(); idle();
        total_cnt++;
        if (reg5 !== 32'h1357_9BDF || Outport_data_out !== 32'h1357_9BDF)
            $display("FAIL preload: reg5=%h out=%h expected 13579bdf", reg5, Outport_data_out);
        else pass_cnt++;
        // Assert clear mid-cycle while loads are requested.
        Inport_out = 1'b1; r_in[1] = 1'b1; PCin = 1'b1;
        #3 clear = 1'b0;
        #1;
        obs = '{reg1, reg2, reg3, reg4, reg5, reg6, reg7, regMDR, PC_VALUE, HI_VALUE,
                LO_VALUE, IR_VALUE, MAR_to_chip, Outport_data_out, BusMuxOut_out};
        for (int i = 0; i < 15; i++) begin
            total_cnt++;
            if (obs[i] !== 32'h0) $display("FAIL midreset_out%0d: got %h expected 00000000", i, obs[i]);
            else pass_cnt++;
        end
        idle(); Zhi_out = 1'b1; #1;
        total_cnt++;
        if (BusMuxOut_out !== 32'h0) $display("FAIL midreset_zhi: got %h expected 00000000", BusMuxOut_out);
        else pass_cnt++;
        idle(); Zlo_out = 1'b1; #1;
        total_cnt++;
        if (BusMuxOut_out !== 32'h0) $display("FAIL midreset_zlo: got %h expected 00000000", BusMuxOut_out);
        else pass_cnt++;
        idle();
        #2 clear = 1'b1;
        put_reg(1, 32'h0BAD_F00D);
        total_cnt++;
        if (reg1 !== 32'h0BAD_F00D) $display("FAIL load_after_reset: got %h expected 0badf00d", reg1);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mdr_pc();
        test_inc_pc();
        test_ir_c();
        test_neg_not();
        test_alu_directed();
        test_alu_random();
        test_bus_priority();
        test_outport_mar();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
